// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio types: sample width, stereo frame, capture FSM states
package audio_pkg;

  localparam int SAMPLE_W = 16;

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/i2s_adc_rx_if.sv
// rtl/i2s_adc_rx_if.sv - streaming source handshake (data/valid/ready) for captured frames
interface i2s_adc_rx_if #(
  parameter int W = 32
);
  logic [W-1:0] source_data;
  logic         source_valid;
  logic         source_ready;

  modport master (output source_data, output source_valid, input source_ready);
  modport slave  (input source_data, input source_valid, output source_ready);
endinterface

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - small synchronous frame FIFO; a push into a full FIFO is
// accepted when a pop happens in the same cycle, otherwise it is reported as dropped
module sample_fifo
  import audio_pkg::*;
#(
  parameter type DATA_T = stereo_sample_t,
  parameter int  DEPTH  = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push_i,
  input  DATA_T push_data_i,
  input  logic  ready_i,
  output DATA_T head_o,
  output logic  valid_o,
  output logic  drop_o
);

  localparam int AW = $clog2(DEPTH);

  DATA_T            mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             empty;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = !empty && ready_i;
  assign do_push = push_i && (!full || do_pop);
  assign drop_o  = push_i && !do_push;
  assign valid_o = !empty;
  assign head_o  = mem_q[rd_q];

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/i2s_adc_rx.sv
// rtl/i2s_adc_rx.sv - I2S capture from the codec ADC (codec is bit/word clock master),
// assembles left/right words into stereo frames and queues them for the stream source
module i2s_adc_rx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W   = audio_pkg::SAMPLE_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           enable,
  input  logic           aud_bclk,
  input  logic           aud_adclrck,
  input  logic           aud_adcdat,
  i2s_adc_rx_if.master   src,
  output logic           overflow,
  input  logic           clr_ovf
);

  localparam int CW = $clog2(SAMPLE_W + 1);

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } frame_t;

  // identical two-flop paths keep bclk, lrck and data mutually aligned
  logic [1:0]          bclk_sync_q;
  logic [1:0]          lrck_sync_q;
  logic [1:0]          dat_sync_q;
  logic                bclk_d_q;
  logic                lrck_prev_q;

  rx_state_e           state_q, state_d;
  logic                chan_q, chan_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] shreg_q, shreg_d;
  logic [SAMPLE_W-1:0] left_hold_q, left_hold_d;
  logic                left_ok_q, left_ok_d;
  logic                ovf_q;

  logic                sync_bclk;
  logic                sync_lrck;
  logic                sync_dat;
  logic                bclk_rise;
  logic                lrck_chg;
  logic [SAMPLE_W-1:0] shifted;
  logic                push;
  frame_t              push_data;
  frame_t              head;
  logic                drop;

  assign sync_bclk = bclk_sync_q[1];
  assign sync_lrck = lrck_sync_q[1];
  assign sync_dat  = dat_sync_q[1];
  assign bclk_rise = sync_bclk && !bclk_d_q;
  assign lrck_chg  = (sync_lrck != lrck_prev_q);
  assign shifted   = {shreg_q[SAMPLE_W-2:0], sync_dat};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      dat_sync_q  <= '0;
      bclk_d_q    <= 1'b0;
      lrck_prev_q <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[0], aud_bclk};
      lrck_sync_q <= {lrck_sync_q[0], aud_adclrck};
      dat_sync_q  <= {dat_sync_q[0], aud_adcdat};
      bclk_d_q    <= sync_bclk;
      if (bclk_rise) begin
        lrck_prev_q <= sync_lrck;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      chan_q      <= CH_L;
      cnt_q       <= '0;
      shreg_q     <= '0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      left_hold_q <= left_hold_d;
      left_ok_q   <= left_ok_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    chan_d          = chan_q;
    cnt_d           = cnt_q;
    shreg_d         = shreg_q;
    left_hold_d     = left_hold_q;
    left_ok_d       = left_ok_q;
    push            = 1'b0;
    push_data.left  = left_hold_q;
    push_data.right = shifted;

    if (!enable) begin
      state_d   = IDLE;
      left_ok_d = 1'b0;
    end else if (bclk_rise) begin
      if (lrck_chg) begin
        // the bit under a word-clock change is the I2S delay slot and is dropped
        cnt_d = '0;
        case (state_q)
          IDLE: begin
            if (sync_lrck == CH_L) begin
              state_d = SHIFT;
              chan_d  = CH_L;
            end
          end
          SHIFT: begin
            chan_d    = sync_lrck;
            left_ok_d = 1'b0;
          end
          default: begin
            state_d = SHIFT;
            chan_d  = sync_lrck;
            if (sync_lrck == CH_L) begin
              left_ok_d = 1'b0;
            end
          end
        endcase
      end else if (state_q == SHIFT) begin
        shreg_d = shifted;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(SAMPLE_W - 1)) begin
          state_d = WAIT;
          if (chan_q == CH_L) begin
            left_hold_d = shifted;
            left_ok_d   = 1'b1;
          end else begin
            push      = left_ok_q;
            left_ok_d = 1'b0;
          end
        end
      end
    end
  end

  sample_fifo #(
    .DATA_T (frame_t),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset_n),
    .push_i      (push),
    .push_data_i (push_data),
    .ready_i     (src.source_ready),
    .head_o      (head),
    .valid_o     (src.source_valid),
    .drop_o      (drop)
  );

  assign src.source_data = head;

  // a drop in the same cycle as a clear wins, so no overflow event is lost
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  assign overflow = ovf_q;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// tb/tb_i2s_adc_rx.sv - codec-driven bench for i2s_adc_rx with a frame scoreboard
module tb_i2s_adc_rx;

  logic clk;
  logic reset_n;
  logic enable;
  logic aud_bclk;
  logic aud_adclrck;
  logic aud_adcdat;
  logic overflow;
  logic clr_ovf;

  int checks;
  int failures;
  logic [31:0] exp_q [$];

  i2s_adc_rx_if #(.W(32)) src ();

  i2s_adc_rx #(
    .SAMPLE_W   (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .aud_bclk    (aud_bclk),
    .aud_adclrck (aud_adclrck),
    .aud_adcdat  (aud_adcdat),
    .src         (src.master),
    .overflow    (overflow),
    .clr_ovf     (clr_ovf)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // one I2S slot: lrck changes with bclk low, word MSB follows one bit later
  task automatic send_slot(input logic lr, input logic [15:0] w, input int nbits, input bit chk_lat);
    for (int p = 0; p < nbits; p++) begin
      aud_bclk    = 1'b0;
      aud_adclrck = lr;
      aud_adcdat  = (p >= 1 && p <= 16) ? w[16-p] : 1'($urandom);
      #163 aud_bclk = 1'b1;
      if (chk_lat && p == 16) begin
        check("pre_valid", 32'(src.source_valid), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("latency_valid", 32'(src.source_valid), 32'd1);
        #90;
      end else begin
        #163;
      end
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input bit expect_it);
    if (expect_it) exp_q.push_back({l, r});
    send_slot(1'b0, l, 32, 1'b0);
    send_slot(1'b1, r, 32, 1'b0);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 src.source_ready = v;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    check("empty_after_drain", 32'(src.source_valid), 32'd0);
  endtask

  always @(negedge clk) begin
    if (reset_n && src.source_valid && src.source_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", src.source_data, 32'hxxxx_xxxx);
      end else begin
        check("frame", src.source_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks           = 0;
    failures         = 0;
    reset_n          = 1'b0;
    enable           = 1'b1;
    aud_bclk         = 1'b0;
    aud_adclrck      = 1'b1;
    aud_adcdat       = 1'b0;
    clr_ovf          = 1'b0;
    src.source_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_valid", 32'(src.source_valid), 32'd0);
    check("rst_data", src.source_data, 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // preamble right slot, then a single timed frame
    send_slot(1'b1, 16'h0000, 32, 1'b0);
    exp_q.push_back(32'hA5C3_1234);
    send_slot(1'b0, 16'hA5C3, 32, 1'b0);
    send_slot(1'b1, 16'h1234, 32, 1'b1);
    check("hold_valid", 32'(src.source_valid), 32'd1);
    check("hold_data", src.source_data, 32'hA5C3_1234);
    set_ready(1'b1);
    wait_drain();

    // streaming with ready held high
    for (int k = 0; k < 10; k++) begin
      send_frame(16'(k), ~16'(k), 1'b1);
    end
    wait_drain();
    check("stream_ovf", 32'(overflow), 32'd0);

    // back-pressure: four retained, two dropped
    set_ready(1'b0);
    for (int k = 0; k < 4; k++) begin
      send_frame(16'h0100 + 16'(k), 16'h0200 + 16'(k), 1'b1);
    end
    check("ovf_at_full", 32'(overflow), 32'd0);
    for (int k = 4; k < 6; k++) begin
      send_frame(16'h0100 + 16'(k), 16'h0200 + 16'(k), 1'b0);
    end
    check("ovf_set", 32'(overflow), 32'd1);
    check("full_valid", 32'(src.source_valid), 32'd1);
    check("full_head", src.source_data, 32'h0100_0200);
    @(posedge clk);
    #1 clr_ovf = 1'b1;
    @(posedge clk);
    #1 clr_ovf = 1'b0;
    @(negedge clk);
    check("ovf_cleared", 32'(overflow), 32'd0);
    set_ready(1'b1);
    wait_drain();

    // enable rises in the middle of a right slot
    enable = 1'b0;
    send_slot(1'b0, 16'h7777, 32, 1'b0);
    fork
      send_slot(1'b1, 16'hDEAD, 32, 1'b0);
      begin
        #3260 enable = 1'b1;
      end
    join
    send_frame(16'h5A5A, 16'hC3C3, 1'b1);
    wait_drain();

    // short left slot, then short right slot, then a good frame
    send_slot(1'b0, 16'h1111, 11, 1'b0);
    send_slot(1'b1, 16'h2222, 32, 1'b0);
    send_slot(1'b0, 16'h3333, 32, 1'b0);
    send_slot(1'b1, 16'h4444, 11, 1'b0);
    send_frame(16'h7E81, 16'h0FF0, 1'b1);
    wait_drain();

    // asynchronous reset in the middle of a left word
    set_ready(1'b0);
    for (int k = 0; k < 5; k++) begin
      send_frame(16'hF000 + 16'(k), 16'h0F00 + 16'(k), 1'b0);
    end
    check("pre_rst_ovf", 32'(overflow), 32'd1);
    check("pre_rst_valid", 32'(src.source_valid), 32'd1);
    send_slot(1'b0, 16'hBEEF, 9, 1'b0);
    #37 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(src.source_valid), 32'd0);
    check("mid_rst_data", src.source_data, 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    repeat (3) @(posedge clk);
    #5 reset_n = 1'b1;
    send_slot(1'b0, 16'hBEEF, 23, 1'b0);
    send_slot(1'b1, 16'hCAFE, 32, 1'b0);
    send_frame(16'h1357, 16'h2468, 1'b1);
    set_ready(1'b1);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_adc_rx.md
Name: i2s_adc_rx

Overview:
- Audio-input counterpart of the DAC output path.
- Captures stereo samples from the WM8731 codec ADC over I2S. The codec is bus master and drives AUD_BCLK and AUD_ADCLRCK; the block samples AUD_ADCDAT.
- Buffers completed left/right frames in a small FIFO and presents them to the soc_system fabric on an Avalon-ST source (data/valid/ready).
- Sits in soc_system_top alongside the existing read_data/source_ready output path.

Parameters:
- SAMPLE_W, 16, bits per channel captured (MSB-first). Extra bits in a slot are ignored.
- FIFO_DEPTH, 4, stereo frames buffered. Must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock, 50 MHz (CLOCK_50)
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  capture enable; 0 forces IDLE (FIFO contents are kept)
- aud_bclk  in  1  codec bit clock, asynchronous to clk
- aud_adclrck  in  1  codec ADC word clock; 0 = left, 1 = right
- aud_adcdat  in  1  codec ADC serial data
- source_data  out  2*SAMPLE_W  {left, right} frame at FIFO head
- source_valid  out  1  FIFO not empty
- source_ready  in  1  downstream accepts source_data this cycle
- overflow  out  1  sticky: a completed frame was dropped because the FIFO was full
- clr_ovf  in  1  synchronous clear of overflow

Behaviour:
- Reset values: source_valid=0, source_data=0, overflow=0. FIFO is empty, FSM is IDLE, all shift/hold registers are 0.
- Synchronisation:
  - aud_bclk, aud_adclrck and aud_adcdat each pass through an identical 2-flop synchroniser, so they stay aligned.
  - bclk_rise = sync_bclk & ~bclk_d, where bclk_d is a third register. All serial logic advances only on bclk_rise.
- Word-clock edge: on bclk_rise, lrck_chg = (sync_lrck != lrck_prev); lrck_prev is then updated.
- I2S one-bit delay: the bclk_rise on which lrck_chg=1 is the delay slot. Its data bit is discarded and bit_cnt is set to 0.
- FSM states and transitions:
  - IDLE: wait for enable and a lrck_chg to 0 (left start), then go to SHIFT with chan=L. Any right start seen in IDLE is ignored.
  - SHIFT: on each bclk_rise without lrck_chg, shift aud_adcdat into the LSB of shreg (MSB-first) and increment bit_cnt.
    - When bit_cnt reaches SAMPLE_W: if chan=L, latch left_hold and set left_ok; if chan=R, go to the frame-complete logic. Then go to WAIT.
  - WAIT: ignore bits until lrck_chg.
    - lrck_chg to 1: chan=R, go to SHIFT.
    - lrck_chg to 0: chan=L, clear left_ok, go to SHIFT.
  - lrck_chg in SHIFT before SAMPLE_W bits (short slot): discard the partial word, clear left_ok, restart on the new channel.
- Frame complete: when the right word completes and left_ok=1, push {left_hold, right_word} and clear left_ok. If left_ok=0, the right word is discarded.
- Latency: the push occurs within 1 clk of the bclk_rise of the last right bit. source_valid asserts on the next clk after the push.
- enable deasserted: return to IDLE immediately and clear left_ok. A frame in flight is lost. No partial push ever occurs.
- FIFO rules:
  - Pop on source_valid & source_ready.
  - A push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the frame is dropped and overflow is set.
  - Pointers wrap modulo FIFO_DEPTH.
  - source_data is the registered head entry and is stable while valid & !ready.
- overflow: set has priority over a simultaneous clr_ovf.
- Asynchronous reset mid-frame: all state clears. Capture resumes only at the next left start.

Decomposition:
- Package audio_pkg: SAMPLE_W default constant; typedef stereo_sample_t as a packed struct {left, right}; FSM state enum (IDLE, SHIFT, WAIT).
- Sub-module sample_fifo: parameterised synchronous FIFO carrying stereo_sample_t, with the same-cycle push-when-full-with-pop rule. Reused later by the DAC path.

Test Plan:
- I2S codec model (BCLK = 3.072 MHz, 48 kHz, 32-bit slots), enable=1, left=16'hA5C3, right=16'h1234 -> one frame with source_data=32'hA5C3_1234 and source_valid=1 within 3 clk of the last right bit.
- Stream frames k=0..9 with left=k, right=~k, source_ready held 1 -> 10 pops in order, no overflow.
- source_ready=0 for 6 frames, FIFO_DEPTH=4 -> 4 frames retained (frames 0..3), frames 4 and 5 dropped, overflow=1. clr_ovf pulse -> overflow=0.
- enable rises while lrck=1 (mid right slot) -> first right word discarded, first output is the next complete L+R pair.
- Short slot (lrck toggles after 10 bits) -> partial word discarded, no push. The next full frame is captured correctly.
- reset_n pulsed low mid-left-word -> outputs return to reset values immediately. The next full frame after release is captured correctly.
